// File: rtl/sync_fifo_buffer_if.sv
// Handshake and status bundle of sync_fifo_buffer. The master side is the
// producer/consumer pair and the slave side is the FIFO itself.
interface sync_fifo_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  almost_full;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, almost_full, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, almost_full, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky
// errors. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH = 64,
    parameter int AF_LEVEL   = 60,
    parameter int AE_LEVEL   = 4
) (
    input logic                clk,
    input logic                rst,
    sync_fifo_buffer_if.slave  bus
);

    typedef logic [ADDR_WIDTH:0]   ptr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam ptr_t DEPTH_C = ptr_t'(FIFO_DEPTH);
    localparam ptr_t AF_C    = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_C    = ptr_t'(AE_LEVEL);

    if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("sync_fifo_buffer: FIFO_DEPTH must equal 2**ADDR_WIDTH");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > FIFO_DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH) begin : g_level_check
        $error("sync_fifo_buffer: AF_LEVEL and AE_LEVEL must lie in 0..FIFO_DEPTH");
    end

    word_t mem [0:(1 << ADDR_WIDTH)-1];
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    ptr_t  count_q;
    logic  overflow_q;
    logic  underflow_q;

    logic  full_c;
    logic  empty_c;
    logic  wr_accept;
    logic  rd_accept;

    // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
    always_comb begin
        full_c    = (count_q == DEPTH_C);
        empty_c   = (count_q == '0);
        wr_accept = bus.wr_en & ~full_c;
        rd_accept = bus.rd_en & ~empty_c;
    end

    // NOTE: storage carries no reset; pointers and count alone define which words are live.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;

            unique case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            overflow_q  <= overflow_q  | (bus.wr_en & full_c);
            underflow_q <= underflow_q | (bus.rd_en & empty_c);
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always on display; rd_en only acknowledges it.
    assign bus.rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign bus.rd_valid = ~empty_c;
`else
    word_t rd_data_q;
    logic  rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // The pointer distance, wrap bit included, must always agree with the count.
    assert property (@(posedge clk) disable iff (rst) ptr_t'(wr_ptr - rd_ptr) == count_q);

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench for sync_fifo_buffer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_sync_fifo_buffer;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int AF    = 60;
    localparam int AE    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sync_fifo_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    sync_fifo_buffer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(DEPTH),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the queue holds live words in FIFO order.
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_udf;
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            max_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        check("count",        32'(bus.count),        32'(n));
        check("full",         32'(bus.full),         32'(n == DEPTH));
        check("almost_full",  32'(bus.almost_full),  32'(n >= AF));
        check("empty",        32'(bus.empty),        32'(n == 0));
        check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        check("overflow",     32'(bus.overflow),     32'(m_ovf));
        check("underflow",    32'(bus.underflow),    32'(m_udf));
`ifdef FIFO_FWFT_EN
        check("rd_valid",     32'(bus.rd_valid),     32'(n != 0));
        if (n != 0) check("rd_data", 32'(bus.rd_data), 32'(q[0]));
`else
        check("rd_valid",     32'(bus.rd_valid),     32'(m_valid));
        check("rd_data",      32'(bus.rd_data),      32'(m_data));
`endif
        if (n > max_count) max_count = n;
    endtask

    // Drive one clock of stimulus, advance the model, then check after the edge.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re, input logic rs);
        int n;
        bit wa;
        bit ra;
        n = q.size();
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        rst         = rs;
        if (rs) begin
            q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            wa = we && (n < DEPTH);
            ra = re && (n > 0);
            if (we && n == DEPTH) m_ovf = 1'b1;
            if (re && n == 0)     m_udf = 1'b1;
            m_valid = ra;
            if (ra) m_data = q.pop_front();
            if (wa) q.push_back(wd);
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        check_state();
    endtask

    initial begin
        int pw;
        int pr;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        max_count   = 0;
        m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_data = '0;

        // Reset state
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);

        // Fill with 0x01..0x40, then one write too many
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_count", 32'(bus.count), 32'd64);
        check("fill_full",  32'(bus.full),  32'd1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf_set",   32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count),    32'd64);

        // Drain in order, then one read too many
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
            check("drain_data", 32'(bus.rd_data), 32'(i));
`endif
        end
        check("drain_empty", 32'(bus.empty),        32'd1);
        check("drain_ae",    32'(bus.almost_empty), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("udf_set", 32'(bus.underflow), 32'd1);

        // Pointer wrap: 40 in, 40 out, 40 in
        cycle(1'b0, '0, 1'b0, 1'b1);
        max_count = 0;
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("wrap_max",   32'(max_count), 32'd40);
        check("wrap_count", 32'(bus.count), 32'd40);

        // Simultaneous write and read while full
        for (int i = 0; i < 24; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        check("both_full_count", 32'(bus.count),    32'd63);
        check("both_full_ovf",   32'(bus.overflow), 32'd1);

        // Simultaneous write and read while empty
        for (int i = 0; i < 63; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        check("both_empty_count", 32'(bus.count),     32'd1);
        check("both_empty_udf",   32'(bus.underflow), 32'd1);

        // Reset mid-traffic at count 30 with both requests high
        for (int i = 0; i < 29; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd30);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        check("mid_rst_count", 32'(bus.count),     32'd0);
        check("mid_rst_valid", 32'(bus.rd_valid),  32'd0);
        check("mid_rst_ovf",   32'(bus.overflow),  32'd0);
        check("mid_rst_udf",   32'(bus.underflow), 32'd0);

        // Simultaneous write and read at count 10
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        check("both_mid_count", 32'(bus.count), 32'd10);

        // Single word into an empty FIFO
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        check("fwft_valid", 32'(bus.rd_valid), 32'd1);
        check("fwft_data",  32'(bus.rd_data),  32'hA5);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("fwft_pop_valid", 32'(bus.rd_valid), 32'd0);
`else
        check("single_valid_pre", 32'(bus.rd_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("single_valid", 32'(bus.rd_valid), 32'd1);
        check("single_data",  32'(bus.rd_data),  32'hA5);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("single_valid_drop", 32'(bus.rd_valid), 32'd0);
`endif

        // Random traffic in phases biased toward filling, draining and balance
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 3)
                0:       begin pw = 75; pr = 30; end
                1:       begin pw = 30; pr = 75; end
                default: begin pw = 50; pr = 50; end
            endcase
            cycle(1'($urandom_range(99) < pw), 8'($urandom),
                  1'($urandom_range(99) < pr), 1'($urandom_range(999) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
